// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the IF-stage, MEM-stage and unified-memory handshake
//             signals seen by mem_port_arbiter. The master modport is the
//             arbiter's view; the slave modport is the environment's view
//             (pipeline stages plus memory).
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction fetch side
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_valid_o;

   // data load/store side
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              dm_valid_o;

   // unified memory side
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   // pipeline control / status
   logic              stall_o;
   logic              err_o;

   modport master (
      input  if_req_i, if_addr_i,
      output if_rdata_o, if_valid_o,
      input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      output dm_rdata_o, dm_valid_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i,
      output stall_o, err_o
   );

   modport slave (
      output if_req_i, if_addr_i,
      input  if_rdata_o, if_valid_o,
      output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      input  dm_rdata_o, dm_valid_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i,
      input  stall_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported unified memory between the IF and MEM
//             pipeline stages. Data accesses win over fetches, each access is
//             a req/ack handshake with a bounded busy time, completions are
//             returned as one-cycle valid pulses, and the pipeline is stalled
//             while any stage request is still unanswered.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  wire logic          clk_i,
   input  wire logic          rst_n_i,
   mem_port_arbiter_if.master bus
);

   // counter only has to reach TIMEOUT-1
   localparam int             CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_IF_BUSY = 2'd1;
   localparam logic [1:0] ST_DM_BUSY = 2'd2;

   logic [1:0]        state;
   logic [1:0]        next_state;

   logic [CNT_W-1:0]  busy_cnt;
   logic              cnt_last;

   logic              if_eligible;
   logic              dm_eligible;

   logic              grant_if;
   logic              grant_dm;
   logic              busy;
   logic              done_ack;
   logic              done_timeout;
   logic              done_if;
   logic              done_dm;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] if_rdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              if_valid;
   logic              dm_valid;
   logic              err;

   // A requester whose valid pulse is high still holds req this cycle; its
   // own valid register doubles as the one-cycle mask so it is not re-served.
   assign if_eligible = bus.if_req_i & ~if_valid;
   assign dm_eligible = bus.dm_req_i & ~dm_valid;

   // Abort point: the final busy cycle allowed without an acknowledge.
   assign cnt_last = (busy_cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection: dm outranks if, busy ends on ack or timeout.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (dm_eligible) begin
               next_state = ST_DM_BUSY;
            end else if (if_eligible) begin
               next_state = ST_IF_BUSY;
            end
         end
         ST_IF_BUSY, ST_DM_BUSY: begin
            if (bus.mem_ack_i || cnt_last) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Output decode: grant strobes in IDLE, completion strobes in BUSY.
   // An ack on the last allowed cycle counts as a normal completion.
   always_comb begin
      grant_if     = 1'b0;
      grant_dm     = 1'b0;
      busy         = 1'b0;
      done_ack     = 1'b0;
      done_timeout = 1'b0;
      done_if      = 1'b0;
      done_dm      = 1'b0;
      case (state)
         ST_IDLE: begin
            grant_dm = dm_eligible;
            grant_if = ~dm_eligible & if_eligible;
         end
         ST_IF_BUSY: begin
            busy         = 1'b1;
            done_ack     = bus.mem_ack_i;
            done_timeout = ~bus.mem_ack_i & cnt_last;
            done_if      = bus.mem_ack_i | cnt_last;
         end
         ST_DM_BUSY: begin
            busy         = 1'b1;
            done_ack     = bus.mem_ack_i;
            done_timeout = ~bus.mem_ack_i & cnt_last;
            done_dm      = bus.mem_ack_i | cnt_last;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Memory request capture: latch the granted access and hold it stable
   // until the access completes or is abandoned.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_dm) begin
         mem_req   <= 1'b1;
         mem_we    <= bus.dm_we_i;
         mem_addr  <= bus.dm_addr_i;
         mem_wdata <= bus.dm_wdata_i;
      end else if (grant_if) begin
         // fetch data lines are don't-care, so they are left untouched
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= bus.if_addr_i;
      end else if (done_if || done_dm) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
      end
   end

   // Busy-cycle counter: cleared on grant, advanced on each unanswered cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_cnt <= '0;
      end else if (grant_dm || grant_if) begin
         busy_cnt <= '0;
      end else if (busy && !bus.mem_ack_i && !cnt_last) begin
         busy_cnt <= busy_cnt + 1'b1;
      end
   end

   // Fetch response: capture instruction (or zero on abort) and pulse valid.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         if_rdata <= '0;
         if_valid <= 1'b0;
      end else begin
         if_valid <= done_if;
         if (done_if) begin
            if_rdata <= done_ack ? bus.mem_rdata_i : '0;
         end
      end
   end

   // Data response: loads capture read data, stores keep the old value,
   // an aborted access returns zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dm_rdata <= '0;
         dm_valid <= 1'b0;
      end else begin
         dm_valid <= done_dm;
         if (done_dm && done_timeout) begin
            dm_rdata <= '0;
         end else if (done_dm && !mem_we) begin
            dm_rdata <= bus.mem_rdata_i;
         end
      end
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err <= 1'b0;
      end else if (done_timeout) begin
         err <= 1'b1;
      end
   end

   assign bus.mem_req_o   = mem_req;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_wdata_o = mem_wdata;
   assign bus.if_rdata_o  = if_rdata;
   assign bus.if_valid_o  = if_valid;
   assign bus.dm_rdata_o  = dm_rdata;
   assign bus.dm_valid_o  = dm_valid;
   assign bus.err_o       = err;

   // Stall while either stage waits; released in its completion cycle.
   assign bus.stall_o = (bus.if_req_i & ~if_valid) | (bus.dm_req_i & ~dm_valid);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: transaction vectors,
//             directed multi-cycle sequences, and random traffic compared
//             with a transaction-timing reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int TO = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TO)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_dm;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;      // cycles after mem_req rises before ack
      logic [31:0] rdata;
      int          exp_lat;    // cycles from request to valid pulse
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = '0;
      bus.dm_req_i    = 1'b0;
      bus.dm_we_i     = 1'b0;
      bus.dm_addr_i   = '0;
      bus.dm_wdata_i  = '0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req",   bus.mem_req_o,   0);
      chk("rst_mem_we",    bus.mem_we_o,    0);
      chk("rst_mem_addr",  bus.mem_addr_o,  0);
      chk("rst_mem_wdata", bus.mem_wdata_o, 0);
      chk("rst_if_rdata",  bus.if_rdata_o,  0);
      chk("rst_dm_rdata",  bus.dm_rdata_o,  0);
      chk("rst_if_valid",  bus.if_valid_o,  0);
      chk("rst_dm_valid",  bus.dm_valid_o,  0);
      chk("rst_err",       bus.err_o,       0);
      chk("rst_stall",     bus.stall_o,     0);
      rst_n = 1'b1;
   endtask

   // One isolated access from an idle arbiter; memory answers after 'delay'.
   task automatic run_txn(input vec_t v, input string tag);
      int  lat;
      bit  seen;
      logic vld;
      @(posedge clk); #1;
      if (v.is_dm) begin
         bus.dm_req_i   = 1'b1;
         bus.dm_we_i    = v.we;
         bus.dm_addr_i  = v.addr;
         bus.dm_wdata_i = v.wdata;
      end else begin
         bus.if_req_i  = 1'b1;
         bus.if_addr_i = v.addr;
      end
      seen = 1'b0;
      lat  = -1;
      for (int k = 0; k < 40 && !seen; k++) begin
         bus.mem_ack_i   = (k == v.delay + 1);
         bus.mem_rdata_i = (k == v.delay + 1) ? v.rdata : $urandom;
         @(negedge clk);
         if (k == 0) chk({tag, "_stall_pending"}, bus.stall_o, 1);
         if (k == 1) begin
            chk({tag, "_mem_req"},  bus.mem_req_o,  1);
            chk({tag, "_mem_addr"}, bus.mem_addr_o, v.addr);
            chk({tag, "_mem_we"},   bus.mem_we_o,   {31'd0, v.is_dm & v.we});
            if (v.is_dm && v.we) chk({tag, "_mem_wdata"}, bus.mem_wdata_o, v.wdata);
         end
         vld = v.is_dm ? bus.dm_valid_o : bus.if_valid_o;
         if (vld) begin
            seen = 1'b1;
            lat  = k;
            chk({tag, "_rdata"}, v.is_dm ? bus.dm_rdata_o : bus.if_rdata_o, v.exp_rdata);
            chk({tag, "_stall_done"}, bus.stall_o, 0);
            chk({tag, "_mem_req_done"}, bus.mem_req_o, 0);
            chk({tag, "_err"}, bus.err_o, {31'd0, v.exp_err});
         end
         @(posedge clk); #1;
      end
      bus.if_req_i  = 1'b0;
      bus.dm_req_i  = 1'b0;
      bus.mem_ack_i = 1'b0;
      chk({tag, "_latency"}, lat, v.exp_lat);
      @(negedge clk);
      chk({tag, "_single_pulse"}, bus.if_valid_o | bus.dm_valid_o, 0);
      chk({tag, "_no_reissue"}, bus.mem_req_o, 0);
   endtask

   // Both stages request together: dm first, fetch granted in dm's valid cycle.
   task automatic seq_simultaneous();
      @(posedge clk); #1;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h0000_0300;
      bus.dm_req_i  = 1'b1;
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h0000_0100;
      for (int k = 0; k < 8; k++) begin
         bus.mem_ack_i   = (k == 2 || k == 5);
         bus.mem_rdata_i = (k == 2) ? 32'h1111_2222 : (k == 5) ? 32'h3333_4444 : $urandom;
         if (k == 4) bus.dm_req_i = 1'b0;
         if (k == 7) bus.if_req_i = 1'b0;
         @(negedge clk);
         chk("sim_mem_req",  bus.mem_req_o,  (k == 1 || k == 2 || k == 4 || k == 5));
         chk("sim_dm_valid", bus.dm_valid_o, (k == 3));
         chk("sim_if_valid", bus.if_valid_o, (k == 6));
         chk("sim_stall",    bus.stall_o,    (k < 6));
         if (k == 1) begin
            chk("sim_dm_addr", bus.mem_addr_o, 32'h0000_0100);
            chk("sim_dm_we",   bus.mem_we_o,   0);
         end
         if (k == 4) begin
            chk("sim_if_addr", bus.mem_addr_o, 32'h0000_0300);
            chk("sim_if_we",   bus.mem_we_o,   0);
         end
         if (k == 3) chk("sim_dm_rdata", bus.dm_rdata_o, 32'h1111_2222);
         if (k == 6) chk("sim_if_rdata", bus.if_rdata_o, 32'h3333_4444);
         @(posedge clk); #1;
      end
      bus.mem_ack_i = 1'b0;
   endtask

   // Asynchronous reset during a data access, then a clean fetch.
   task automatic seq_reset_mid();
      vec_t v;
      @(posedge clk); #1;
      bus.dm_req_i  = 1'b1;
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h0000_0400;
      bus.mem_ack_i = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("rmid_busy_mem_req", bus.mem_req_o, 1);
      #2;
      rst_n        = 1'b0;
      bus.dm_req_i = 1'b0;
      #1;
      chk("rmid_mem_req", bus.mem_req_o,  0);
      chk("rmid_dm_valid", bus.dm_valid_o, 0);
      chk("rmid_err",     bus.err_o,      0);
      chk("rmid_stall",   bus.stall_o,    0);
      @(posedge clk);
      @(negedge clk);
      chk("rmid_dm_valid_hold", bus.dm_valid_o, 0);
      rst_n = 1'b1;
      v = '{is_dm: 1'b0, we: 1'b0, addr: 32'h0000_0500, wdata: 32'h0, delay: 0,
            rdata: 32'h0BAD_F00D, exp_lat: 2, exp_rdata: 32'h0BAD_F00D, exp_err: 1'b0};
      run_txn(v, "rmid_fetch");
   endtask

   // Random traffic against a model built from grant times and latencies.
   task automatic run_random(input int ncyc);
      bit          if_pend, dm_pend, dm_we_m;
      logic [31:0] if_a, dm_a, dm_wd;
      bit          job, job_dm, job_we, job_to;
      int          job_start, job_end, d, r;
      logic [31:0] job_addr, job_wd, job_data;
      bit          e_ifv, e_dmv, e_err, p_ifv, p_dmv, busy_n, ack_n;
      logic [31:0] e_ifr, e_dmr;
      if_pend = 0; dm_pend = 0; dm_we_m = 0; if_a = 0; dm_a = 0; dm_wd = 0;
      job = 0; job_dm = 0; job_we = 0; job_to = 0; job_start = 0; job_end = 0;
      job_addr = 0; job_wd = 0; job_data = 0;
      e_ifv = 0; e_dmv = 0; e_err = 0; p_ifv = 0; p_dmv = 0; e_ifr = 0; e_dmr = 0;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk); #1;
         if (p_ifv) if_pend = 0;
         if (p_dmv) dm_pend = 0;
         if (!if_pend && $urandom_range(1, 0) == 1) begin
            if_pend = 1;
            if_a    = $urandom;
         end
         if (!dm_pend && $urandom_range(2, 0) == 0) begin
            dm_pend = 1;
            dm_we_m = ($urandom_range(1, 0) == 1);
            dm_a    = $urandom;
            dm_wd   = $urandom;
         end
         bus.if_req_i   = if_pend;
         bus.if_addr_i  = if_a;
         bus.dm_req_i   = dm_pend;
         bus.dm_we_i    = dm_we_m;
         bus.dm_addr_i  = dm_a;
         bus.dm_wdata_i = dm_wd;
         busy_n = job && (n >= job_start) && (n <= job_end);
         ack_n  = busy_n && !job_to && (n == job_end);
         bus.mem_ack_i   = ack_n ? 1'b1 : (!busy_n && $urandom_range(3, 0) == 0);
         bus.mem_rdata_i = ack_n ? job_data : $urandom;
         @(negedge clk);
         chk("rnd_mem_req", bus.mem_req_o, busy_n);
         if (busy_n) begin
            chk("rnd_mem_addr", bus.mem_addr_o, job_addr);
            chk("rnd_mem_we",   bus.mem_we_o,   job_we);
            if (job_we) chk("rnd_mem_wdata", bus.mem_wdata_o, job_wd);
         end
         chk("rnd_if_valid", bus.if_valid_o, e_ifv);
         chk("rnd_dm_valid", bus.dm_valid_o, e_dmv);
         chk("rnd_if_rdata", bus.if_rdata_o, e_ifr);
         chk("rnd_dm_rdata", bus.dm_rdata_o, e_dmr);
         chk("rnd_err",      bus.err_o,      e_err);
         chk("rnd_stall",    bus.stall_o,    (if_pend && !e_ifv) || (dm_pend && !e_dmv));
         // grant decision for this cycle: dm first, valid-pulsing requester skipped
         if (!busy_n && ((dm_pend && !e_dmv) || (if_pend && !e_ifv))) begin
            job_dm = dm_pend && !e_dmv;
            job_we = job_dm ? dm_we_m : 1'b0;
            job_addr = job_dm ? dm_a : if_a;
            job_wd   = dm_wd;
            job_data = $urandom;
            r = $urandom_range(9, 0);
            if (r < 7)      d = $urandom_range(3, 0);
            else if (r < 9) d = $urandom_range(TO - 1, 4);
            else            d = $urandom_range(TO + 4, TO - 1);
            if (job_we && d > TO - 2) d = TO - 2;
            job_to    = (d > TO - 1);
            job       = 1;
            job_start = n + 1;
            job_end   = n + 1 + (job_to ? TO - 1 : d);
         end
         p_ifv = e_ifv;
         p_dmv = e_dmv;
         e_ifv = 0;
         e_dmv = 0;
         if (busy_n && n == job_end) begin
            job = 0;
            if (job_dm) begin
               e_dmv = 1;
               if (job_to)       e_dmr = 32'h0;
               else if (!job_we) e_dmr = job_data;
            end else begin
               e_ifv = 1;
               e_ifr = job_to ? 32'h0 : job_data;
            end
            if (job_to) e_err = 1;
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      idle_inputs();

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1,  32'h8C22_0004, 3,  32'h8C22_0004, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         0,  32'h1234_5678, 2,  32'h1234_5678, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 2,  32'h5555_AAAA, 4,  32'h1234_5678, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         15, 32'hCAFE_F00D, 17, 32'hCAFE_F00D, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,         99, 32'h7777_7777, 17, 32'h0000_0000, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         3,  32'hA5A5_5A5A, 5,  32'hA5A5_5A5A, 1'b1};

      do_reset();
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end
      seq_simultaneous();
      seq_reset_mid();
      do_reset();
      run_random(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Sequences each access over a req/ack memory handshake and returns data plus a one-cycle valid pulse to the requesting stage.
- Drives a global pipeline stall while any stage request is outstanding.
- Enforces a bounded-latency timeout with a sticky error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max busy cycles allowed without mem_ack_i before abort (≥2).

Ports:
- clk_i, in, 1, clock, rising edge.
- rst_n_i, in, 1, reset, asynchronous, active-low.
- if_req_i, in, 1, fetch request, held until if_valid_o.
- if_addr_i, in, ADDR_W, fetch address, stable while if_req_i.
- if_rdata_o, out, DATA_W, fetched instruction, registered.
- if_valid_o, out, 1, one-cycle completion pulse for fetch.
- dm_req_i, in, 1, data request, held until dm_valid_o.
- dm_we_i, in, 1, 1 = store, 0 = load.
- dm_addr_i, in, ADDR_W, data address.
- dm_wdata_i, in, DATA_W, store data.
- dm_rdata_o, out, DATA_W, load data, registered.
- dm_valid_o, out, 1, one-cycle completion pulse for data.
- mem_req_o, out, 1, memory request level.
- mem_we_o, out, 1, memory write enable.
- mem_addr_o, out, ADDR_W, memory address.
- mem_wdata_o, out, DATA_W, memory write data.
- mem_rdata_i, in, DATA_W, memory read data, valid with mem_ack_i.
- mem_ack_i, in, 1, memory completion, one cycle.
- stall_o, out, 1, pipeline stall (freezes PC, IF/ID, all stage registers).
- err_o, out, 1, sticky timeout error.

Behaviour:
- Reset (rst_n_i low, async): state IDLE; all registered outputs 0, including mem_req_o (drops immediately); counter 0; mask 0; err_o 0. Mid-transaction reset abandons the access; no valid pulse is issued.
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE: eligible requests are those whose req is high and whose requester is not masked.
  - dm has fixed priority over if (older instruction first).
  - On a grant, capture addr/we/wdata into mem_* registers, set mem_req_o=1, clear counter, go to the BUSY state.
  - No eligible request: stay in IDLE.
  - mem_we_o is 0 for fetch; mem_wdata_o is don't-care for fetch.
- BUSY: mem_req_o and mem_* are held stable.
  - When mem_ack_i=1: register mem_rdata_i into if_rdata_o (fetch) or dm_rdata_o (loads only). Pulse the matching valid next cycle, drop mem_req_o, and return to IDLE.
  - Stores pulse dm_valid_o and leave dm_rdata_o unchanged.
- Mask: in the cycle a valid pulse is high, IDLE treats that requester as ineligible, because its req is still high that cycle. The other requester may be granted in that same cycle.
- Latency: req seen in IDLE at cycle 0 → mem_req_o high cycle 1 → ack earliest cycle 1 → valid cycle 2. Minimum 2 cycles; back-to-back dm then if is 4 cycles.
- Timeout: the counter increments each BUSY cycle without ack. If it reaches TIMEOUT-1 with no ack, abort:
  - drop mem_req_o;
  - pulse the requester's valid with rdata = 0;
  - set err_o (stays set until reset);
  - return to IDLE.
  - Ack arriving in the same cycle as the timeout wins, and err_o is not set.
- mem_ack_i while IDLE is ignored.
- stall_o = (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o), combinational.
- Requests that change address while pending are a protocol violation; the captured address is used.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x10; memory acks 1 cycle after mem_req_o with rdata 0x8C220004 → mem_addr_o=0x10, if_valid_o one pulse at cycle 3, if_rdata_o=0x8C220004, stall_o high cycles 0–2, low at the valid cycle.
- Simultaneous: if_req_i and dm_req_i (load 0x100) both rise at cycle 0, ack after 1 cycle → dm served first (mem_addr_o=0x100, mem_we_o=0), dm_valid_o pulse, then fetch granted in the same cycle as the dm valid pulse. No re-issue of the dm access.
- Store: dm_we_i=1, addr 0x20, wdata 0xDEADBEEF → mem_we_o=1, mem_wdata_o=0xDEADBEEF; dm_valid_o pulses and dm_rdata_o keeps its previous value.
- Timeout: TIMEOUT=16, fetch with no ack → mem_req_o deasserts after 16 busy cycles, if_valid_o pulses with if_rdata_o=0, err_o=1 and stays set across later good accesses.
- Reset mid-operation: rst_n_i low during DM_BUSY → mem_req_o, dm_valid_o, and stall-driving state clear immediately without a clock edge. After release, a new fetch completes normally with err_o=0.
- Ack/timeout collision: ack on the final timeout cycle → normal data returned, err_o remains 0.
